serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial adder controller that sequences one 1-bit full-adder datapath, built from two `half_adder` instances, to add two WIDTH-bit operands over WIDTH clock cycles. It owns the operand shift registers, the carry flop, the bit counter and the start/done handshake. It sits between a requester issuing add operations and the shared half-adder datapath, trading area for latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  (a+b) mod 2^WIDTH; held from done until the next accepted start.
- cout  output  1  carry out (bit WIDTH of a+b); held with sum.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch a and b into shift registers, clear carry, clear bit counter, clear sum and cout, go to RUN.
  - Otherwise remain in IDLE with sum and cout held.
- RUN, each cycle:
  - Feed LSB(a_sh), LSB(b_sh) and the carry flop into the full-adder cell. The cell is HA1(a,b), then HA2(s1,cin); cout_bit = c1 | c2.
  - Shift the result bit into sum from the MSB side (sum <= {bit, sum[WIDTH-1:1]}).
  - Shift a_sh and b_sh right by one, update carry, increment the counter.
  - When the counter reaches WIDTH-1 on this cycle's update, go to DONE.
- DONE: done=1 and cout=final carry, for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. There is no queueing and no error flag.
- Counter width is $clog2(WIDTH+1). WIDTH=1 must work: a single RUN cycle.
- Reset, asynchronous at any time including mid-RUN:
  - state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry and counter all 0.
  - After reset release, the first start is accepted normally.

## Timing
- Edge 0: start sampled high in IDLE.
- Edges 1..WIDTH: RUN; busy=1 during this window.
- Edge WIDTH+1: state is DONE; done=1 and sum/cout valid.
- The next start can be accepted at the earliest on edge WIDTH+2 (IDLE), giving a throughput of one add per WIDTH+2 cycles.
- If start is held high continuously, back-to-back operations run at that rate, each using a and b as sampled on its accept edge.
- busy and done are registered, never both high, and glitch-free.
- sum changes only during RUN and on reset. It is stable from done until the next accept.

## Structure
- Shared package serial_adder_pkg holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default WIDTH constant.
- Sub-module serial_fa_bit: a combinational full-adder cell made of two `half_adder` instances plus an OR. It is the only datapath logic.
- Top level: FSM, counter, shift registers and carry flop, in separate always blocks.

## Test plan
All scenarios use WIDTH=8.
- Idle reset check: hold rst_n=0 for 2 cycles, then release -> busy=0, done=0, sum=0x00, cout=0; no activity without start.
- Basic add: start with a=0xA5, b=0x5A -> busy for 8 cycles, done pulse at edge 9, sum=0xFF, cout=0; sum still 0xFF 5 cycles later.
- Full carry ripple: a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0, confirming the carry is cleared between operations.
- Start during RUN: accept a=0x0F, b=0x01; pulse start with a=0xF0, b=0xF0 at edge 3 -> ignored; result sum=0x10, cout=0, single done pulse.
- Reset mid-operation: accept a=0x80, b=0x80; drop rst_n at edge 4 -> immediate busy=0, sum=0, done=0. After release, start a=0x80, b=0x80 -> sum=0x00, cout=1 at edge 9 after the accept.
- Continuous start: hold start=1 with operands changed each accept -> accepts at edges 0, 10, 20; each result matches a golden model; done pulses exactly every 10 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between an add requester (master) and the
// serial adder controller (slave).
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );

endinterface : serial_adder_ctrl_if

// File: rtl/half_adder.sv
// One-bit half adder: sum is the XOR, carry is the AND of the two inputs.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule : half_adder

// File: rtl/serial_fa_bit.sv
// Combinational one-bit full adder built from two half adders and an OR.
// This cell is the entire datapath of the serial adder.
module serial_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha1 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s1),
        .c_o (c1)
    );

    half_adder u_ha2 (
        .a_i (s1),
        .b_i (cin_i),
        .s_o (sum_o),
        .c_o (c2)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign cout_o = c1 | c2;

endmodule : serial_fa_bit

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Adds two WIDTH-bit operands one bit per cycle
// through a single full-adder cell, LSB first. The result is assembled by
// shifting each bit in from the MSB side so that after WIDTH shifts bit 0
// lands in position 0. sum/cout are held from done until the next accept.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);

    localparam int                 CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_shift;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               run;
    logic               last_bit;
    logic               fa_sum;
    logic               fa_cout;

    serial_fa_bit u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        accept   = 1'b0;
        run      = 1'b0;
        last_bit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last_bit = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state,
    // so both outputs come straight from flops and are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Bit counter: cleared on accept, advanced once per processed bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Operand shift registers: load on accept, shift right while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
        end else if (accept) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
        end else if (run) begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
        end
    end

    // Carry flop feeding the cell; cleared at the start of each operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (accept) begin
            carry_q <= 1'b0;
        end else if (run) begin
            carry_q <= fa_cout;
        end
    end

    // Result bit enters at the MSB; written this way so WIDTH=1 needs no
    // empty part-select.
    always_comb begin
        sum_shift            = sum_q >> 1;
        sum_shift[WIDTH-1]   = fa_sum;
    end

    // Result register and carry-out: cleared on accept, built during RUN,
    // carry-out captured on the last bit and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (run) begin
            sum_q <= sum_shift;
            if (last_bit) begin
                cout_q <= fa_cout;
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge, so "after edge k" means the registered state that
// edge k produced.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full transaction with hand-computed result: accept at edge 0, busy
    // after edges 0..7, done after edge 8, idle with held result after edge 9.
    task automatic do_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        cyc();
        bus.start = 1'b0;
        for (int k = 0; k < W; k++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_done_low"}, 32'(bus.done), 32'd0);
            cyc();
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        cyc();
        check({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
        check({tag, "_sum_held"}, 32'(bus.sum), 32'(exp_sum));
    endtask

    initial begin
        logic [W-1:0] a_set [4];
        logic [W-1:0] b_set [4];
        logic [W:0]   model;
        int           cur;
        int           ph;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Idle reset check.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'h00);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        repeat (4) begin
            cyc();
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_sum", 32'(bus.sum), 32'h00);
        end

        // Basic add with held result several cycles later.
        do_add("basic", 8'hA5, 8'h5A, 8'hFF, 1'b0);
        repeat (4) cyc();
        check("basic_sum_late", 32'(bus.sum), 32'hFF);

        // Full carry ripple, then a zero add proving carry is cleared.
        do_add("ripple", 8'hFF, 8'h01, 8'h00, 1'b1);
        do_add("zero", 8'h00, 8'h00, 8'h00, 1'b0);

        // Start pulsed during RUN must be ignored.
        bus.start = 1'b1;
        bus.a     = 8'h0F;
        bus.b     = 8'h01;
        cyc();                                  // edge 0 accept
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        cyc();                                  // edge 1
        cyc();                                  // edge 2
        bus.start = 1'b1;
        bus.a     = 8'hF0;
        bus.b     = 8'hF0;
        cyc();                                  // edge 3, start seen in RUN
        bus.start = 1'b0;
        check("ignore_busy", 32'(bus.busy), 32'd1);
        done_cnt = 0;
        for (int e = 4; e <= 11; e++) begin
            cyc();
            if (bus.done) done_cnt++;
            if (e == 8) begin
                check("ignore_done", 32'(bus.done), 32'd1);
                check("ignore_sum", 32'(bus.sum), 32'h10);
                check("ignore_cout", 32'(bus.cout), 32'd0);
            end
        end
        check("ignore_done_count", 32'(done_cnt), 32'd1);
        check("ignore_idle_after", 32'(bus.busy), 32'd0);
        check("ignore_sum_held", 32'(bus.sum), 32'h10);

        // Asynchronous reset in the middle of an operation.
        bus.start = 1'b1;
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        cyc();                                  // edge 0 accept
        bus.start = 1'b0;
        repeat (3) cyc();                       // edges 1..3
        @(posedge clk);                         // edge 4
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'h00);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("postrst_idle", 32'(bus.busy), 32'd0);
        do_add("postrst", 8'h80, 8'h80, 8'h00, 1'b1);

        // Continuous start: accepts at edges 0, 10, 20 with fresh operands.
        a_set[0] = 8'h12; b_set[0] = 8'h34;
        a_set[1] = 8'hC8; b_set[1] = 8'h64;
        a_set[2] = 8'h7F; b_set[2] = 8'h81;
        a_set[3] = 8'h00; b_set[3] = 8'h00;
        cur       = 0;
        bus.start = 1'b1;
        bus.a     = a_set[0];
        bus.b     = b_set[0];
        for (int t = 0; t < 30; t++) begin
            cyc();
            ph = t % 10;
            if (ph == 0) begin
                cur    = t / 10;
                bus.a  = a_set[cur + 1];
                bus.b  = b_set[cur + 1];
            end
            check("cont_busy", 32'(bus.busy), (ph < 8) ? 32'd1 : 32'd0);
            check("cont_done", 32'(bus.done), (ph == 8) ? 32'd1 : 32'd0);
            if (ph == 8) begin
                model = {1'b0, a_set[cur]} + {1'b0, b_set[cur]};
                check("cont_sum", 32'(bus.sum), 32'(model[W-1:0]));
                check("cont_cout", 32'(bus.cout), 32'(model[W]));
            end
        end
        bus.start = 1'b0;
        cyc();
        check("cont_stop_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
